lpe_bit_scanner: RTL and testbench
==================================

// Module: lpe_bit_scanner
// PURPOSE
//  Parametrised, clocked successor to the 16-to-4 low-priority encoder.
//  Accepts a WIDTH-bit request word over a valid/ready handshake and emits the
//  index of every set bit, one per beat, lowest index first, with a per-beat
//  valid flag f and a last marker. Sits between request sources and any
//  consumer that services set bits in priority order.
// PARAMETERS
//  WIDTH  16                  request word width, >= 2
//  IDXW   $clog2(WIDTH)       index width (derived; do not override)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  W_valid  in   1      request word W is offered
//  W_ready  out  1      block can take a word; combinational = (state==IDLE)
//  W        in   WIDTH  request word; bit i set = request i pending
//  y_valid  out  1      output beat present (registered)
//  y_ready  in   1      consumer takes the current beat
//  y        out  IDXW   index of the current highest-priority set bit
//  f        out  1      1 = y is a real index; 0 = word was all-zero
//  last     out  1      current beat is the final beat of this word
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, y=0, f=0, last=0, y_valid=0. W_ready=1 in
//    the first cycle after rst deasserts. rst wins over every other event.
//  - States: IDLE -> SCAN on W_valid&W_ready; SCAN -> IDLE when a beat with
//    last=1 is taken (y_valid&y_ready&last). No other transitions.
//  - Load (IDLE, W_valid=1 at edge k): pending<=W; y_valid=1 from edge k
//    (visible in cycle k+1); latency one clock, no combinational W->y path.
//  - Priority: y = lowest index i with pending[i]=1. last=1 iff exactly one
//    bit of pending is set. f=1 while pending!=0.
//  - Beat taken (y_valid&y_ready): clear pending[y]; present next set bit on
//    the following cycle (back-to-back beats, one index per clock).
//  - Backpressure: while y_valid&!y_ready, y/f/last/y_valid held stable.
//  - All-zero word: exactly one beat y=0, f=0, last=1; then IDLE.
//  - W_ready=0 throughout SCAN, incl. the cycle the last beat is taken; new
//    word accepted no earlier than the cycle after. W ignored when W_ready=0.
//  - Bit WIDTH-1 alone: single beat y=WIDTH-1, f=1, last=1 (no wrap).
//  - Reset mid-SCAN: remaining bits discarded, outputs to reset values.
//  - Per-word beats = popcount(W), or 1 if W==0; max WIDTH beats.
// CONFIGURATION
//  LPE_MSB_FIRST_EN defined: priority inverted, y = highest set index,
//    beats emitted in descending order; all-zero and handshake rules unchanged.
//  Not defined (default): lowest set index first, as specified above.
// TESTING (WIDTH=16 unless noted; y_ready=1 unless noted)
//  1. W=16'h0001 -> one beat y=0,f=1,last=1; W_ready high again 2 cycles after
//     load.
//  2. W=16'h0154 -> beats y=2,4,6,8 on consecutive cycles, last=1 only on 8.
//  3. W=16'h8000 -> y=15,f=1,last=1; W=16'h0000 -> y=0,f=0,last=1.
//  4. W=16'h5558, y_ready low 3 cycles at beat 2 -> y=4 held stable, then
//     beats 3,4,6,8,10,12,14 complete; W changes during SCAN ignored.
//  5. W=16'hFFFF, rst pulsed on 5th beat -> next cycle y_valid=0,y=0,f=0,
//     last=0,W_ready=1; following W=16'h0002 gives y=1,last=1.
//  6. LPE_MSB_FIRST_EN, WIDTH=8: W=8'hA5 -> beats y=7,5,2,0, last on 0.

Source files
------------

// File: rtl/lpe_bit_scanner.sv
// ---------------------------------------------------------------------------
// lpe_bit_scanner
//
// Clocked successor to the 16-to-4 low-priority encoder. A WIDTH-bit request
// word is taken over a valid/ready handshake. The block then emits the index
// of every set bit, one beat per clock. By default the lowest index comes
// first.
//
// Each beat carries three values:
//   y     index of the bit being serviced
//   f     1 = y is a real index, 0 = the word was all-zero
//   last  1 = final beat of this word
//
// An all-zero word still produces exactly one beat, with y=0, f=0, last=1.
//
// Build option:
//   LPE_MSB_FIRST_EN  When defined, priority is inverted: the highest set
//                     index comes first and beats run in descending order.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   W_valid  in   1      request word offered
//   W_ready  out  1      block can take a word (high only in IDLE)
//   W        in   WIDTH  request word; bit i set = request i pending
//   y_valid  out  1      output beat present (registered)
//   y_ready  in   1      consumer takes the current beat
//   y        out  IDXW   index of the current highest-priority set bit
//   f        out  1      y is a real index (word was non-zero)
//   last     out  1      current beat is the final beat of the word
// ---------------------------------------------------------------------------
module lpe_bit_scanner #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       W_valid,
  output logic                       W_ready,
  input  logic [WIDTH-1:0]           W,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [$clog2(WIDTH)-1:0]   y,
  output logic                       f,
  output logic                       last
);

  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_nxt;
  logic [WIDTH-1:0] bit_one;
  logic             load;
  logic             take;
  logic             advance;

  // Index of the bit to service next.
  // The loop direction sets the priority: the last match wins.
  function automatic logic [IDXW-1:0] prio_idx(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
`ifdef LPE_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = IDXW'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) idx = IDXW'(i);
`endif
    return idx;
  endfunction

  // True when at most one bit is set.
  // This makes the current beat the final one, and it also covers the
  // all-zero word.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) == '0;
  endfunction

  assign bit_one = {{(WIDTH-1){1'b0}}, 1'b1};
  assign W_ready = (state == IDLE);
  assign load    = W_valid & W_ready;
  assign take    = y_valid & y_ready;
  // A taken beat that is not the last one moves the scan to the next set bit.
  assign advance = take & ~last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load)        state_nxt = SCAN;
      SCAN:    if (take & last) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pending_nxt = pending;
    if (load)      pending_nxt = W;
    else if (take) pending_nxt = pending & ~(bit_one << y);
  end

  // Output register stage.
  // Beats are re-encoded from the next pending word, so each index is
  // registered one clock after the word is loaded or the previous beat is
  // taken. There is no combinational path from W to y.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      y       <= '0;
      f       <= 1'b0;
      last    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (load || advance) begin
        y       <= prio_idx(pending_nxt);
        f       <= |pending_nxt;
        last    <= at_most_one(pending_nxt);
        y_valid <= 1'b1;
      end else if (take) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpe_bit_scanner.sv
module tb_lpe_bit_scanner;

`ifdef LPE_MSB_FIRST_EN
  localparam int WIDTH = 8;
`else
  localparam int WIDTH = 16;
`endif
  localparam int IDXW = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             W_valid;
  logic             W_ready;
  logic [WIDTH-1:0] W;
  logic             y_valid;
  logic             y_ready;
  logic [IDXW-1:0]  y;
  logic             f;
  logic             last;

  int n_chk = 0;
  int n_err = 0;

  lpe_bit_scanner #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .W_valid (W_valid),
    .W_ready (W_ready),
    .W       (W),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y       (y),
    .f       (f),
    .last    (last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    while (!W_ready && n < 20) begin
      tick();
      n++;
    end
    chk("w_ready_wait", 32'(W_ready), 32'd1);
    W_valid = 1'b1;
    W       = w;
    tick();
    W_valid = 1'b0;
  endtask

  // Check the beat currently presented, then let one clock pass.
  // y_ready is held as the caller left it.
  task automatic beat(input string tag, input int idx, input logic fe, input logic le);
    chk({tag, "_vld"},   32'(y_valid), 32'd1);
    chk({tag, "_y"},     32'(y),       32'(idx));
    chk({tag, "_f"},     32'(f),       32'(fe));
    chk({tag, "_last"},  32'(last),    32'(le));
    chk({tag, "_wrdy"},  32'(W_ready), 32'd0);
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    W_valid = 1'b0;
    W       = '0;
    y_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_wrdy", 32'(W_ready), 32'd1);
    chk("rst_vld",  32'(y_valid), 32'd0);
    chk("rst_y",    32'(y),       32'd0);
    chk("rst_f",    32'(f),       32'd0);
    chk("rst_last", 32'(last),    32'd0);

`ifdef LPE_MSB_FIRST_EN
    // Descending order for W=8'hA5: bits 7, 5, 2, 0.
    send(8'hA5);
    beat("msb0", 7, 1'b1, 1'b0);
    beat("msb1", 5, 1'b1, 1'b0);
    beat("msb2", 2, 1'b1, 1'b0);
    beat("msb3", 0, 1'b1, 1'b1);
    chk("msb_done_vld", 32'(y_valid), 32'd0);
    chk("msb_done_wrdy", 32'(W_ready), 32'd1);
`else
    // Single bit 0; W_ready returns two cycles after the load edge.
    send(16'h0001);
    beat("t1", 0, 1'b1, 1'b1);
    chk("t1_wrdy_back", 32'(W_ready), 32'd1);
    chk("t1_vld_off",   32'(y_valid), 32'd0);

    // Bits 2, 4, 6, 8 on consecutive cycles.
    send(16'h0154);
    beat("t2a", 2, 1'b1, 1'b0);
    beat("t2b", 4, 1'b1, 1'b0);
    beat("t2c", 6, 1'b1, 1'b0);
    beat("t2d", 8, 1'b1, 1'b1);

    // Top bit only, then an all-zero word.
    send(16'h8000);
    beat("t3_msb", 15, 1'b1, 1'b1);
    send(16'h0000);
    beat("t3_zero", 0, 1'b0, 1'b1);
    chk("t3_wrdy", 32'(W_ready), 32'd1);

    // Backpressure on beat 2, with a new word offered during SCAN.
    // The new word must be ignored.
    send(16'h5558);
    beat("t4a", 3, 1'b1, 1'b0);
    y_ready = 1'b0;
    W_valid = 1'b1;
    W       = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_vld",  32'(y_valid), 32'd1);
      chk("t4_hold_y",    32'(y),       32'd4);
      chk("t4_hold_last", 32'(last),    32'd0);
      tick();
    end
    y_ready = 1'b1;
    beat("t4b", 4, 1'b1, 1'b0);
    W_valid = 1'b0;
    beat("t4c", 6, 1'b1, 1'b0);
    beat("t4d", 8, 1'b1, 1'b0);
    beat("t4e", 10, 1'b1, 1'b0);
    beat("t4f", 12, 1'b1, 1'b0);
    beat("t4g", 14, 1'b1, 1'b1);
    chk("t4_done_vld", 32'(y_valid), 32'd0);

    // Reset asserted while the 5th beat of 16'hFFFF is presented.
    send(16'hFFFF);
    for (int i = 0; i < 4; i++) beat("t5_pre", i, 1'b1, 1'b0);
    chk("t5_beat5_y", 32'(y), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_vld",  32'(y_valid), 32'd0);
    chk("t5_rst_y",    32'(y),       32'd0);
    chk("t5_rst_f",    32'(f),       32'd0);
    chk("t5_rst_last", 32'(last),    32'd0);
    chk("t5_rst_wrdy", 32'(W_ready), 32'd1);
    send(16'h0002);
    beat("t5_after", 1, 1'b1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
